// File: rtl/mext_pipe_unit.sv
// RV32M multiply/divide unit: fixed DEPTH-cycle pipeline with global stall and flush.
// Result is formed combinationally from the last stage; per-stage valid/rd feed the hazard scoreboard.
module mext_pipe_unit #(
  parameter int WORD_W   = 32,
  parameter int REG_W    = 5,
  parameter int DEPTH    = 5,
  parameter int HZ_STAGE = 3
) (
  input  logic                     clk_i,
  input  logic                     rsn_i,
  input  logic                     valid_i,
  input  logic [2:0]               opcode_i,
  input  logic                     rf_we_i,
  input  logic [WORD_W-1:0]        src_a_i,
  input  logic [WORD_W-1:0]        src_b_i,
  input  logic [REG_W-1:0]         rf_waddr_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic                     busy_o,
  output logic                     valid_hz_o,
  output logic [DEPTH-1:0]         stage_valid_o,
  output logic [DEPTH*REG_W-1:0]   stage_waddr_o,
  output logic                     valid_o,
  output logic                     rf_we_o,
  output logic [REG_W-1:0]         rf_waddr_o,
  output logic [WORD_W-1:0]        rf_wdata_o
);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } m_ext_opcode_e;

  typedef struct packed {
    logic              vld;
    logic              we;
    logic [2:0]        op;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [REG_W-1:0]  rd;
  } stage_t;

  localparam logic [WORD_W-1:0] ONE = {{(WORD_W-1){1'b0}}, 1'b1};

  stage_t st [DEPTH];

  // Flush outranks stall; only control bits are cleared, payload is don't-care.
  always_ff @(posedge clk_i) begin
    if (!rsn_i || flush_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        st[k].vld <= 1'b0;
        st[k].we  <= 1'b0;
      end
    end else if (!stall_i) begin
      st[0] <= '{vld: valid_i, we: rf_we_i, op: opcode_i,
                 a: src_a_i, b: src_b_i, rd: rf_waddr_i};
      for (int k = 1; k < DEPTH; k++) begin
        st[k] <= st[k-1];
      end
    end
  end

  logic [DEPTH-1:0] live;

  always_comb begin
    live          = '0;
    stage_valid_o = '0;
    stage_waddr_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      live[k]          = st[k].vld & rsn_i;
      stage_valid_o[k] = live[k] & st[k].we;
      stage_waddr_o[k*REG_W +: REG_W] = stage_valid_o[k] ? st[k].rd : '0;
    end
  end

  assign busy_o     = |live;
  assign valid_hz_o = live[HZ_STAGE-1];
  assign valid_o    = live[DEPTH-1];

  stage_t tl;
  assign tl = st[DEPTH-1];

  logic                mul_sa, mul_sb, div_s, a_neg, b_neg, b_zero;
  logic [2*WORD_W-1:0] a_ext, b_ext, prod;
  logic [WORD_W-1:0]   a_mag, b_mag, dvs, q_mag, r_mag, quo, rem, res;

  // Signed division runs on magnitudes; -2^(W-1)/-1 then naturally wraps to the dividend.
  always_comb begin
    mul_sa = (tl.op == OP_MULH) || (tl.op == OP_MULHSU);
    mul_sb = (tl.op == OP_MULH);
    a_ext  = {{WORD_W{mul_sa & tl.a[WORD_W-1]}}, tl.a};
    b_ext  = {{WORD_W{mul_sb & tl.b[WORD_W-1]}}, tl.b};
    prod   = a_ext * b_ext;

    div_s  = (tl.op == OP_DIV) || (tl.op == OP_REM);
    a_neg  = div_s & tl.a[WORD_W-1];
    b_neg  = div_s & tl.b[WORD_W-1];
    a_mag  = a_neg ? (~tl.a + ONE) : tl.a;
    b_mag  = b_neg ? (~tl.b + ONE) : tl.b;
    b_zero = (tl.b == '0);
    dvs    = b_zero ? ONE : b_mag;
    q_mag  = a_mag / dvs;
    r_mag  = a_mag % dvs;
    quo    = b_zero ? '1 : ((a_neg ^ b_neg) ? (~q_mag + ONE) : q_mag);
    rem    = b_zero ? tl.a : (a_neg ? (~r_mag + ONE) : r_mag);

    case (tl.op)
      OP_MUL:                       res = prod[WORD_W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*WORD_W-1:WORD_W];
      OP_DIV, OP_DIVU:              res = quo;
      default:                      res = rem;
    endcase
  end

  assign rf_wdata_o = valid_o ? res : '0;
  assign rf_waddr_o = valid_o ? tl.rd : '0;
  assign rf_we_o    = valid_o & tl.we & ~stall_i & (tl.rd != '0);

endmodule
